// File: rtl/wb_cmd_master.sv
// wb_cmd_master: single-outstanding command to Wishbone pipelined master bridge.
// Optional bus-cycle timeout enabled by defining WB_CMD_MASTER_TIMEOUT_EN.
module wb_cmd_master #(
  parameter int ADDR_WIDTH     = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_we,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [DATA_WIDTH-1:0] i_cmd_data,
  output logic                  o_wb_cyc,
  output logic                  o_wb_stb,
  output logic                  o_wb_we,
  output logic [ADDR_WIDTH-1:0] o_wb_addr,
  output logic [DATA_WIDTH-1:0] o_wb_odata,
  input  logic                  i_wb_ack,
  input  logic                  i_wb_stall,
  input  logic                  i_wb_err,
  input  logic [DATA_WIDTH-1:0] i_wb_idata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic                  o_rsp_err,
  output logic                  o_busy
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t state, state_d;
  logic cyc_d, stb_d, we_d, rsp_valid_d, rsp_err_d;
  logic done, ok, tmo, in_bus;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] odata_d, rsp_data_d;
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_tmo
    $error("wb_cmd_master: TIMEOUT_CYCLES out of range 1..65535");
  end
  assign in_bus = (state == REQ) || (state == WAIT);
  assign done   = o_wb_cyc && (i_wb_ack || i_wb_err);
  assign ok     = done && i_wb_ack && !i_wb_err;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  // Counter is zero in the first REQ cycle, so the abort edge ends cycle TIMEOUT_CYCLES.
  assign tmo = in_bus && !done && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge i_clk)
    if (i_reset || !in_bus) tmo_cnt <= '0;
    else tmo_cnt <= tmo_cnt + 16'd1;
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_d     = state;
    cyc_d       = o_wb_cyc;
    stb_d       = o_wb_stb;
    we_d        = o_wb_we;
    addr_d      = o_wb_addr;
    odata_d     = o_wb_odata;
    rsp_valid_d = o_rsp_valid;
    rsp_err_d   = o_rsp_err;
    rsp_data_d  = o_rsp_data;
    case (state)
      IDLE: if (i_cmd_valid) begin
        state_d = REQ;
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
        we_d    = i_cmd_we;
        addr_d  = i_cmd_addr;
        odata_d = i_cmd_data;
      end
      REQ, WAIT: if (done || tmo) begin
        state_d     = RESP;
        cyc_d       = 1'b0;
        stb_d       = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_err_d   = !ok;
        rsp_data_d  = (ok && !o_wb_we) ? i_wb_idata : '0;
      end else if (state == REQ && !i_wb_stall) begin
        state_d = WAIT;
        stb_d   = 1'b0;
      end
      RESP: if (i_rsp_ready) begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk)
    if (i_reset) begin
      state       <= IDLE;
      o_wb_cyc    <= 1'b0;
      o_wb_stb    <= 1'b0;
      o_wb_we     <= 1'b0;
      o_wb_addr   <= '0;
      o_wb_odata  <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_err   <= 1'b0;
      o_rsp_data  <= '0;
      o_cmd_ready <= 1'b1;
      o_busy      <= 1'b0;
    end else begin
      state       <= state_d;
      o_wb_cyc    <= cyc_d;
      o_wb_stb    <= stb_d;
      o_wb_we     <= we_d;
      o_wb_addr   <= addr_d;
      o_wb_odata  <= odata_d;
      o_rsp_valid <= rsp_valid_d;
      o_rsp_err   <= rsp_err_d;
      o_rsp_data  <= rsp_data_d;
      o_cmd_ready <= state_d == IDLE;
      o_busy      <= state_d != IDLE;
    end
endmodule
